seq_stage_ctrl: RTL and testbench

- Multi-cycle sequencer for the Y86-64 SEQ datapath.
- Steps each instruction through the stages FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, and drives one-hot stage enables.
- Owns the architectural PC register and computes the next PC.
- Tracks processor status (AOK/HLT/ADR/INS), stops on any non-AOK status, and applies a bounded-wait handshake to fetch and data-memory access.

---
 rtl/y86_pkg.sv | 43 ++++
 rtl/next_pc_sel.sv | 24 ++
 rtl/seq_stage_ctrl.sv | 129 ++++++++++++
 tb/tb_seq_stage_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the SEQ sequencer: instruction codes, status
// codes, stage states and the data-memory usage predicate.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALTED
    } stage_t;

    // Instructions that touch data memory and so must wait for mem_ack.
    function automatic logic uses_dmem(input logic [3:0] icode);
        case (icode)
            I_RMMOV, I_MRMOV, I_CALL, I_RET, I_PUSH, I_POP: uses_dmem = 1'b1;
            default:                                        uses_dmem = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for the SEQ datapath: call target, return address,
// conditional branch target or fall-through.
module next_pc_sel
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valM,
    input  logic [63:0] valP,
    output logic [63:0] next_pc
);

    always_comb begin
        next_pc = valP;
        case (icode)
            I_CALL:  next_pc = valC;
            I_RET:   next_pc = valM;
            I_JXX:   next_pc = cnd ? valC : valP;
            default: next_pc = valP;
        endcase
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle Y86-64 SEQ sequencer: steps each instruction through six stages,
// owns the PC and status, and bounds the wait on instruction/data memory.
module seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valM,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_ack,
    input  logic        imem_error,
    input  logic        mem_ack,
    input  logic        dmem_error,
    output logic [63:0] PC,
    output logic        f_en,
    output logic        d_en,
    output logic        e_en,
    output logic        m_en,
    output logic        w_en,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [63:0] instr_count
);

    stage_t      state, state_next;
    stat_t       stat_q, stat_next;
    logic [31:0] wait_cnt;
    logic [63:0] next_pc;
    logic        timeout;

    next_pc_sel u_next_pc_sel (
        .icode   (icode),
        .cnd     (cnd),
        .valC    (valC),
        .valM    (valM),
        .valP    (valP),
        .next_pc (next_pc)
    );

    // This is the last permitted waiting cycle; an ack arriving now still wins.
    assign timeout = (MAX_WAIT != 0) && (wait_cnt == MAX_WAIT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            stat_q      <= STAT_AOK;
            PC          <= PC_RESET;
            instr_count <= '0;
            wait_cnt    <= '0;
        end else begin
            state  <= state_next;
            stat_q <= stat_next;
            if (state == S_PCUPD) begin
                PC          <= next_pc;
                instr_count <= instr_count + 64'd1;
            end
            if (state_next != state)
                wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEMORY)
                wait_cnt <= wait_cnt + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        stat_next  = stat_q;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    if (imem_error) begin
                        stat_next  = STAT_ADR;
                        state_next = S_HALTED;
                    end else if (!instr_valid) begin
                        stat_next  = STAT_INS;
                        state_next = S_HALTED;
                    end else if (icode == I_HALT) begin
                        stat_next  = STAT_HLT;
                        state_next = S_HALTED;
                    end else begin
                        state_next = S_DECODE;
                    end
                end else if (timeout) begin
                    stat_next  = STAT_ADR;
                    state_next = S_HALTED;
                end
            end
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_MEMORY;
            S_MEMORY: begin
                if (!uses_dmem(icode)) begin
                    state_next = S_WRITEBACK;
                end else if (mem_ack) begin
                    if (dmem_error) begin
                        stat_next  = STAT_ADR;
                        state_next = S_HALTED;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end else if (timeout) begin
                    stat_next  = STAT_ADR;
                    state_next = S_HALTED;
                end
            end
            S_WRITEBACK: state_next = S_PCUPD;
            S_PCUPD:     state_next = S_FETCH;
            S_HALTED:    state_next = S_HALTED;
            default:     state_next = S_FETCH;
        endcase
    end

    always_comb begin
        f_en   = (state == S_FETCH);
        d_en   = (state == S_DECODE);
        e_en   = (state == S_EXECUTE);
        m_en   = (state == S_MEMORY);
        w_en   = (state == S_WRITEBACK);
        halted = (state == S_HALTED);
    end

    assign stat = stat_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Scoreboard bench for seq_stage_ctrl: stimulus queues the expected
// architectural result of each instruction, a monitor checks it when it lands.
module tb_seq_stage_ctrl;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valC, valM, valP;
    logic        instr_valid, imem_ack, imem_error, mem_ack, dmem_error;
    logic [63:0] pc_out;
    logic        f_en, d_en, e_en, m_en, w_en;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] instr_count;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  stat;
        logic        halted;
        logic [63:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_pc = 64'h100;
    logic [63:0] exp_cnt = 64'd0;
    logic [63:0] last_cnt = 64'd0;
    logic        last_halted = 1'b0;

    seq_stage_ctrl #(.PC_RESET(64'h100), .MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .icode       (icode),
        .cnd         (cnd),
        .valC        (valC),
        .valM        (valM),
        .valP        (valP),
        .instr_valid (instr_valid),
        .imem_ack    (imem_ack),
        .imem_error  (imem_error),
        .mem_ack     (mem_ack),
        .dmem_error  (dmem_error),
        .PC          (pc_out),
        .f_en        (f_en),
        .d_en        (d_en),
        .e_en        (e_en),
        .m_en        (m_en),
        .w_en        (w_en),
        .stat        (stat),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_en(input string name, input logic [4:0] req);
        check(name, {59'd0, f_en, d_en, e_en, m_en, w_en}, {59'd0, req});
    endtask

    task automatic push_exp(input logic [63:0] p, input logic [2:0] s, input logic h, input logic [63:0] c);
        exp_t e;
        e.pc = p; e.stat = s; e.halted = h; e.cnt = c;
        sb.push_back(e);
    endtask

    // Monitor: a retirement (count change) or a halt is a DUT result to score.
    always @(posedge clk) begin
        #1;
        if (!rst && (instr_count != last_cnt || (halted && !last_halted))) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_event: actual count=%0h halted=%0b required none", instr_count, halted);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_pc", pc_out, e.pc);
                check("sb_stat", {61'd0, stat}, {61'd0, e.stat});
                check("sb_halted", {63'd0, halted}, {63'd0, e.halted});
                check("sb_count", instr_count, e.cnt);
            end
        end
        last_cnt    = instr_count;
        last_halted = halted;
    end

    task automatic idle_inputs();
        icode = I_NOP; cnd = 1'b0; valC = '0; valM = '0; valP = '0;
        instr_valid = 1'b1; imem_ack = 1'b0; imem_error = 1'b0;
        mem_ack = 1'b0; dmem_error = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        idle_inputs();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        exp_pc  = 64'h100;
        exp_cnt = 64'd0;
    endtask

    // Runs one instruction from FETCH with a fetch ack in the first cycle.
    task automatic exec_instr(input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p,
                              input logic [63:0] m, input logic cn, input int mem_delay, input logic derr);
        logic [63:0] npc;
        case (ic)
            I_CALL:  npc = c;
            I_RET:   npc = m;
            I_JXX:   npc = cn ? c : p;
            default: npc = p;
        endcase
        if (derr) begin
            push_exp(exp_pc, STAT_ADR, 1'b1, exp_cnt);
        end else begin
            exp_pc  = npc;
            exp_cnt = exp_cnt + 64'd1;
            push_exp(exp_pc, STAT_AOK, 1'b0, exp_cnt);
        end
        check_en("fetch_en", 5'b10000);
        icode = ic; valC = c; valP = p; valM = m; cnd = cn; instr_valid = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check_en("decode_en", 5'b01000);
        @(negedge clk);
        check_en("execute_en", 5'b00100);
        @(negedge clk);
        if (uses_dmem(ic)) begin
            for (int k = 0; k <= mem_delay; k++) begin
                check_en("memory_en", 5'b00010);
                mem_ack    = (k == mem_delay);
                dmem_error = derr && (k == mem_delay);
                @(negedge clk);
            end
        end else begin
            check_en("memory_en", 5'b00010);
            @(negedge clk);
        end
        mem_ack = 1'b0; dmem_error = 1'b0;
        if (derr) begin
            repeat (3) begin
                check_en("halted_en", 5'b00000);
                check("halted_flag", {63'd0, halted}, 64'd1);
                @(negedge clk);
            end
            return;
        end
        check_en("writeback_en", 5'b00001);
        @(negedge clk);
        check_en("pcupd_en", 5'b00000);
        @(negedge clk);
    endtask

    task automatic fetch_fault(input logic [3:0] ic, input logic valid, input logic ierr, input logic [2:0] s);
        push_exp(exp_pc, s, 1'b1, exp_cnt);
        check_en("fault_fetch_en", 5'b10000);
        icode = ic; instr_valid = valid; imem_error = ierr; imem_ack = 1'b1;
        @(negedge clk);
        idle_inputs();
        repeat (2) begin
            imem_ack = 1'b1; mem_ack = 1'b1;
            @(negedge clk);
            check_en("fault_halted_en", 5'b00000);
            check("fault_frozen_pc", pc_out, exp_pc);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_inputs();
        do_reset(2);
        check("reset_pc", pc_out, 64'h100);
        check("reset_stat", {61'd0, stat}, 64'd1);
        check("reset_count", instr_count, 64'd0);
        check("reset_halted", {63'd0, halted}, 64'd0);
        check_en("reset_en", 5'b10000);

        exec_instr(I_NOP,   64'h0,   64'h101, 64'h0,  1'b0, 0, 1'b0);
        exec_instr(I_JXX,   64'h40,  64'h109, 64'h0,  1'b0, 0, 1'b0);
        exec_instr(I_JXX,   64'h40,  64'h109, 64'h0,  1'b1, 0, 1'b0);
        exec_instr(I_CALL,  64'h200, 64'h49,  64'h0,  1'b0, 0, 1'b0);
        exec_instr(I_RET,   64'h0,   64'h201, 64'h2A, 1'b0, 0, 1'b0);
        exec_instr(I_MRMOV, 64'h8,   64'h34,  64'h77, 1'b0, 3, 1'b0);
        exec_instr(I_OP,    64'h0,   64'h36,  64'h0,  1'b1, 0, 1'b0);

        // Reset asserted while MEMORY waits on an outstanding access.
        check_en("mid_fetch_en", 5'b10000);
        icode = I_MRMOV; valP = 64'h3A; imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_en("mid_memory_en", 5'b00010);
        do_reset(1);
        check_en("mid_reset_en", 5'b10000);
        check("mid_reset_pc", pc_out, 64'h100);
        check("mid_reset_count", instr_count, 64'd0);

        exec_instr(I_RET, 64'h0, 64'h101, 64'h2A, 1'b0, 0, 1'b1);
        check("derr_pc", pc_out, 64'h100);
        check("derr_stat", {61'd0, stat}, 64'd3);

        do_reset(1);
        fetch_fault(I_HALT, 1'b1, 1'b0, STAT_HLT);
        do_reset(1);
        fetch_fault(I_NOP, 1'b0, 1'b0, STAT_INS);
        do_reset(1);
        fetch_fault(I_NOP, 1'b0, 1'b1, STAT_ADR);

        // Fetch timeout: four waiting cycles without imem_ack.
        do_reset(1);
        push_exp(64'h100, STAT_ADR, 1'b1, 64'd0);
        repeat (3) @(negedge clk);
        check_en("fwait3_en", 5'b10000);
        check("fwait3_halted", {63'd0, halted}, 64'd0);
        @(negedge clk);
        check("fwait4_halted", {63'd0, halted}, 64'd1);
        check("fwait4_stat", {61'd0, stat}, 64'd3);

        // Data-memory timeout: four MEMORY cycles without mem_ack.
        do_reset(1);
        push_exp(64'h100, STAT_ADR, 1'b1, 64'd0);
        icode = I_PUSH; valP = 64'h102; imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        repeat (4) begin
            check_en("mwait_en", 5'b00010);
            @(negedge clk);
        end
        check_en("mwait_halted_en", 5'b00000);
        check("mwait_pc", pc_out, 64'h100);

        do_reset(1);
        exec_instr(I_NOP, 64'h0, 64'h101, 64'h0, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
